// File: rtl/ram_burst_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_burst_ctrl_if
//   Bundles every handshake and RAM-side signal of ram_burst_ctrl.
//   Parameters: AW (address width), DW (data width).
//   Modports:
//     slave  - the burst controller itself: accepts commands, write beats
//              and read-beat acceptance, and drives the RAM we/addr/din.
//     master - the surrounding environment: upstream command/data source,
//              downstream read sink and the RAM's dout.
//   Signal groups:
//     cmd_*  burst command (valid/ready, write flag, start address, len-1)
//     wd_*   write beat stream (valid/ready, data)
//     rd_*   read beat stream (valid/ready, data)
//     done   one-cycle pulse after the last beat of a burst
//     ram_*  RAM port (we, addr, din from controller; dout to controller)
// ---------------------------------------------------------------------------
interface ram_burst_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          wd_valid;
    logic          wd_ready;
    logic [DW-1:0] wd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wd_valid, wd_data,
        input  rd_ready,
        input  ram_dout,
        output cmd_ready, wd_ready, rd_valid, rd_data, done,
        output ram_we, ram_addr, ram_din
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wd_valid, wd_data,
        output rd_ready,
        output ram_dout,
        input  cmd_ready, wd_ready, rd_valid, rd_data, done,
        input  ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// ram_burst_ctrl
//   Burst access controller in front of a single-port synchronous RAM with a
//   one-cycle read latency. Accepts a command (start address, beats-1,
//   direction), streams write beats into the RAM at one beat per cycle, or
//   fetches read beats (address, capture, present) at one beat per three
//   cycles. Addresses wrap modulo 2^AW.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    ram_burst_ctrl_if.slave (command, write/read streams, done,
//            RAM we/addr/din/dout)
// ---------------------------------------------------------------------------
module ram_burst_ctrl #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_burst_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_CAP  = 3'd3,
        RD_OUT  = 3'd4
    } state_t;

    state_t        state_q,     state_d;
    logic [AW-1:0] cur_addr_q,  cur_addr_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic [DW-1:0] rd_data_q,   rd_data_d;
    logic          done_q,      done_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cur_addr_d  = bus.cmd_addr;
                    remaining_d = bus.cmd_len;
                    state_d     = bus.cmd_write ? WRITE : RD_ADDR;
                end
            end

            WRITE: begin
                if (bus.wd_valid) begin
                    if (remaining_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Natural overflow gives the modulo-depth wrap.
                        cur_addr_d  = cur_addr_q + AW'(1);
                        remaining_d = remaining_q - AW'(1);
                    end
                end
            end

            // RAM samples cur_addr at the end of this cycle (we is low).
            RD_ADDR: state_d = RD_CAP;

            // RAM dout now reflects cur_addr; latch it so it stays stable
            // for however long the downstream stalls.
            RD_CAP: begin
                rd_data_d = bus.ram_dout;
                state_d   = RD_OUT;
            end

            RD_OUT: begin
                if (bus.rd_ready) begin
                    if (remaining_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cur_addr_d  = cur_addr_q + AW'(1);
                        remaining_d = remaining_q - AW'(1);
                        state_d     = RD_ADDR;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshakes are pure state decodes; the RAM write strobe is
    // qualified by wd_valid so an idle upstream never writes.
    always_comb begin
        bus.cmd_ready = (state_q == IDLE);
        bus.wd_ready  = (state_q == WRITE);
        bus.rd_valid  = (state_q == RD_OUT);
        bus.rd_data   = rd_data_q;
        bus.done      = done_q;
        bus.ram_we    = (state_q == WRITE) && bus.wd_valid;
        bus.ram_addr  = cur_addr_q;
        bus.ram_din   = bus.wd_data;
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
module tb_ram_burst_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ram_burst_ctrl_if #(.AW(4), .DW(8)) bus ();

    ram_burst_ctrl #(.AW(4), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: 16x8, synchronous write, registered read.
    logic [7:0] env_ram [16];
    int         wr_count;
    always @(posedge clk) begin
        if (bus.ram_we) begin
            env_ram[bus.ram_addr] <= bus.ram_din;
            wr_count <= wr_count + 1;
        end
        bus.ram_dout <= env_ram[bus.ram_addr];
    end

    // Reference memory: contents the RAM must hold after each burst.
    logic [7:0] model_mem [16];
    logic [7:0] wbuf [16];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Write burst: beats wbuf[0..len]; gap_pct% of cycles offer no beat;
    // busy_poke offers a random command on every cycle of the burst.
    task automatic run_write(input int addr, input int len, input int gap_pct, input bit busy_poke);
        int         beat;
        int         cyc;
        bit         v;
        logic [3:0] exp_a;
        beat = 0;
        cyc  = 0;
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_cmd_ready actual=%b required=1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'(addr);
        bus.cmd_len   = 4'(len);
        tick();
        bus.cmd_valid = 1'b0;
        while (beat <= len && cyc < 200) begin
            v = ($urandom_range(99) >= 32'(gap_pct));
            bus.wd_valid = v;
            bus.wd_data  = wbuf[beat];
            if (busy_poke) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = 1'($urandom);
                bus.cmd_addr  = 4'($urandom);
                bus.cmd_len   = 4'($urandom);
            end
            #1;
            exp_a = 4'(addr + beat);
            total++;
            if (bus.ram_we !== v || bus.wd_ready !== 1'b1 || bus.cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL wr_strobe beat=%0d we=%b wd_ready=%b cmd_ready=%b required we=%b wd_ready=1 cmd_ready=0",
                         beat, bus.ram_we, bus.wd_ready, bus.cmd_ready, v);
            end
            if (v) begin
                total++;
                if (bus.ram_addr !== exp_a || bus.ram_din !== wbuf[beat]) begin
                    bad++;
                    $display("FAIL wr_beat beat=%0d addr=%0d din=%02h required addr=%0d din=%02h",
                             beat, bus.ram_addr, bus.ram_din, exp_a, wbuf[beat]);
                end
            end
            tick();
            if (v) begin
                model_mem[exp_a] = wbuf[beat];
                beat++;
            end
            cyc++;
        end
        bus.wd_valid  = 1'b0;
        bus.cmd_valid = 1'b0;
        total++;
        if (beat <= len) begin
            bad++;
            $display("FAIL wr_timeout beats=%0d required=%0d", beat, len + 1);
        end
        total++;
        if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.wd_ready !== 1'b0) begin
            bad++;
            $display("FAIL wr_done done=%b cmd_ready=%b wd_ready=%b required 1 1 0",
                     bus.done, bus.cmd_ready, bus.wd_ready);
        end
        tick();
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL wr_done_pulse done=%b required=0", bus.done);
        end
    endtask

    // Read burst; stall<0 picks a random 0..3 cycle stall per beat.
    task automatic run_read(input int addr, input int len, input int stall);
        int         cyc;
        int         st;
        logic [3:0] exp_a;
        logic [7:0] exp_d;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'(addr);
        bus.cmd_len   = 4'(len);
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            cyc = 1;
            while (bus.rd_valid !== 1'b1 && cyc < 8) begin
                total++;
                if (bus.ram_we !== 1'b0) begin
                    bad++;
                    $display("FAIL rd_no_write we=%b required=0", bus.ram_we);
                end
                tick();
                cyc++;
            end
            exp_a = 4'(addr + k);
            exp_d = model_mem[exp_a];
            total++;
            if (cyc != 3) begin
                bad++;
                $display("FAIL rd_latency beat=%0d cycles=%0d required=3", k, cyc);
            end
            total++;
            if (bus.rd_data !== exp_d || bus.ram_addr !== exp_a) begin
                bad++;
                $display("FAIL rd_beat beat=%0d data=%02h addr=%0d required data=%02h addr=%0d",
                         k, bus.rd_data, bus.ram_addr, exp_d, exp_a);
            end
            st = (stall < 0) ? int'($urandom_range(3)) : stall;
            bus.rd_ready = 1'b0;
            repeat (st) begin
                tick();
                total++;
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d || bus.ram_addr !== exp_a) begin
                    bad++;
                    $display("FAIL rd_hold beat=%0d valid=%b data=%02h addr=%0d required 1 %02h %0d",
                             k, bus.rd_valid, bus.rd_data, bus.ram_addr, exp_d, exp_a);
                end
            end
            bus.rd_ready = 1'b1;
            tick();
            bus.rd_ready = 1'b0;
            total++;
            if (bus.done !== (k == len)) begin
                bad++;
                $display("FAIL rd_done beat=%0d done=%b required=%b", k, bus.done, (k == len));
            end
        end
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_end cmd_ready=%b rd_valid=%b required 1 0", bus.cmd_ready, bus.rd_valid);
        end
        tick();
    endtask

    task automatic test_reset;
        // Asserted before any clock edge: outputs must already be defined.
        #3;
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.wd_ready !== 1'b0 || bus.rd_valid !== 1'b0 ||
            bus.ram_we !== 1'b0 || bus.ram_addr !== 4'd0 || bus.rd_data !== 8'd0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset cmd_ready=%b wd_ready=%b rd_valid=%b we=%b addr=%0d rd_data=%02h done=%b required 1 0 0 0 0 00 0",
                     bus.cmd_ready, bus.wd_ready, bus.rd_valid, bus.ram_we, bus.ram_addr, bus.rd_data, bus.done);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        run_write(4, 3, 0, 1'b0);
        run_read(4, 3, 0);
    endtask

    task automatic test_wrap;
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC; wbuf[3] = 8'hDD;
        run_write(14, 3, 0, 1'b0);
        run_read(14, 3, 0);
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        run_write(0, 15, 0, 1'b0);
        run_read(0, 15, -1);
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        run_write(7, 5, 50, 1'b0);
        run_read(7, 5, 5);
    endtask

    task automatic test_busy_cmd;
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        run_write(10, 6, 25, 1'b1);
        run_read(10, 6, -1);
    endtask

    task automatic test_random;
        int a;
        int l;
        for (int n = 0; n < 10; n++) begin
            a = int'($urandom_range(15));
            l = int'($urandom_range(15));
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            if ($urandom_range(1) == 1) run_write(a, l, int'($urandom_range(40)), 1'($urandom));
            else                        run_read(a, l, -1);
        end
    endtask

    task automatic test_reset_mid_burst;
        int wr_before;
        // Leave a non-zero value in rd_data so the reset clearing it is visible.
        wbuf[0] = 8'h5A;
        run_write(9, 0, 0, 1'b0);
        run_read(9, 0, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'd0;
        bus.cmd_len   = 4'd7;
        tick();
        bus.cmd_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.wd_valid = 1'b1;
            bus.wd_data  = 8'(b + 1);
            tick();
            model_mem[b] = 8'(b + 1);
        end
        bus.wd_data = 8'd3;
        #2;
        wr_before = wr_count;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.ram_we !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wd_ready !== 1'b0 || bus.rd_valid !== 1'b0 ||
            bus.ram_addr !== 4'd0 || bus.rd_data !== 8'd0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid we=%b cmd_ready=%b wd_ready=%b rd_valid=%b addr=%0d rd_data=%02h done=%b required 0 1 0 0 0 00 0",
                     bus.ram_we, bus.cmd_ready, bus.wd_ready, bus.rd_valid, bus.ram_addr, bus.rd_data, bus.done);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.wd_valid = 1'b0;
        tick();
        total++;
        if (wr_count != wr_before) begin
            bad++;
            $display("FAIL reset_no_write writes=%0d required=%0d", wr_count, wr_before);
        end
        run_read(0, 2, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        wr_count = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        bus.rd_ready  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            env_ram[i]   = 8'($urandom);
            model_mem[i] = env_ram[i];
        end
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_busy_cmd();
        test_random();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Command-driven access controller that sits in front of the 16x8 single-port synchronous RAM and acts as the initiator on its we/addr/din/dout interface. It accepts a burst command (start address, length, direction), streams write data into the RAM or streams read data out, and handles backpressure with valid/ready handshakes. Addresses wrap modulo RAM depth. The block hides the RAM's one-cycle read latency and its read-or-write-per-cycle restriction from upstream logic.

## Interface
- AW, 4, address width; RAM depth 2^AW
- DW, 8, data width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high; equals (state==IDLE)
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  start address
- cmd_len  in  AW  beats minus one (0 → 1 beat, 15 → 16 beats)
- wd_valid  in  1  write beat offered
- wd_ready  out  1  equals (state==WRITE)
- wd_data  in  DW  write beat data
- rd_valid  out  1  read beat valid; equals (state==RD_OUT)
- rd_ready  in  1  downstream accepts read beat
- rd_data  out  DW  registered read beat data
- done  out  1  one-cycle pulse after final beat of any burst
- ram_we  out  1  to RAM we; combinational = (state==WRITE) & wd_valid
- ram_addr  out  AW  to RAM addr; = cur_addr register
- ram_din  out  DW  to RAM din; = wd_data
- ram_dout  in  DW  from RAM dout (valid one cycle after address sampled with we=0)

## Operation
- Registers: state, cur_addr (AW), remaining (AW), rd_data (DW), done.
- States: IDLE, WRITE, RD_ADDR, RD_CAP, RD_OUT.
- IDLE: on cmd_valid: load cur_addr←cmd_addr, remaining←cmd_len; go WRITE if cmd_write else RD_ADDR.
- WRITE: each cycle with wd_valid: RAM writes wd_data at cur_addr; if remaining==0 → IDLE, done←1; else cur_addr←cur_addr+1, remaining−1. wd_valid low: no write, no advance.
- RD_ADDR: ram_we=0, RAM samples cur_addr at end of cycle → RD_CAP.
- RD_CAP: rd_data←ram_dout → RD_OUT.
- RD_OUT: rd_valid=1, rd_data and ram_addr held stable. On rd_ready: remaining==0 → IDLE, done←1; else cur_addr+1, remaining−1 → RD_ADDR.
- Address arithmetic modulo 2^AW: 15+1 = 0 for AW=4; bursts may wrap and may be 16 beats (full RAM).
- cmd_valid outside IDLE ignored (cmd_ready=0); no queueing.
- wd_valid outside WRITE ignored; ram_we never asserted outside WRITE.
- rd_ready outside RD_OUT ignored.

## Timing
- Reset (async, immediate): state=IDLE, cur_addr=0, remaining=0, rd_data=0, done=0; hence cmd_ready=1, wd_ready=0, rd_valid=0, ram_we=0, ram_addr=0. Reset mid-burst aborts with no further RAM writes; already-written locations keep their data.
- Write: command accepted edge E0; first beat may be written in cycle after E0. Sustained 1 beat/cycle. done high in cycle after final write edge.
- Read: command accepted edge E0; rd_valid high 3 cycles after E0 (RD_ADDR, RD_CAP, RD_OUT). Sustained 1 beat per 3 cycles with rd_ready held high.
- done coincides with state=IDLE, so a new command can be accepted in the done cycle.
- ram_we, ram_din combinational from state/wd_valid/wd_data; upstream must hold wd_data stable while wd_valid is high and unaccepted.

## Test plan
- Reset: rst_n low mid-cycle → cmd_ready=1, rd_valid=0, wd_ready=0, ram_we=0, ram_addr=0, rd_data=0, done=0 immediately.
- Write addr 4 len 3 data 0x11,0x22,0x33,0x44 back-to-back → ram_we high 4 cycles at addrs 4..7, done one cycle later; read addr 4 len 3 → rd_data 0x11,0x22,0x33,0x44, first rd_valid 3 cycles after acceptance.
- Wrap: write addr 14 len 3 data 0xAA..0xDD → addrs 14,15,0,1; read addr 14 len 3 returns 0xAA,0xBB,0xCC,0xDD; 16-beat burst from addr 0 covers all locations once.
- Backpressure/gaps: write with wd_valid toggling → ram_we only on valid cycles, addresses contiguous; read with rd_ready low 5 cycles → rd_valid, rd_data, ram_addr stable, no beat lost or duplicated.
- Busy command: cmd_valid with new command during WRITE → ignored, original burst completes unchanged.
- Reset mid-burst: rst_n low after 2 of 8 write beats (addr 0, data 1..8) → ram_we=0 immediately, IDLE; read-back shows addrs 0,1 = 1,2, addr 2 unchanged.
